// File: rtl/bldc_encoder_check_scheduler_if.sv
// Signal bundle between a BLDC channel's encoder/hall counters and its consistency monitor.
// The master drives the counters and controls; the slave reports the check results.
interface bldc_encoder_check_scheduler_if #(
    parameter int unsigned ENCODER_COUNTER_WIDTH = 15,
    parameter int unsigned HALL_COUNTER_WIDTH    = 8,
    parameter int unsigned STRIKE_WIDTH          = 4
);
    logic                             enable;
    logic [ENCODER_COUNTER_WIDTH-1:0] enc_count;
    logic [HALL_COUNTER_WIDTH-1:0]    hall_count;
    logic                             fault_clear;
    logic                             fault;
    logic [STRIKE_WIDTH-1:0]          strike_count;
    logic                             window_done;
    logic [ENCODER_COUNTER_WIDTH-1:0] enc_delta;
    logic [HALL_COUNTER_WIDTH-1:0]    hall_delta;

    modport master (
        output enable, enc_count, hall_count, fault_clear,
        input  fault, strike_count, window_done, enc_delta, hall_delta
    );

    modport slave (
        input  enable, enc_count, hall_count, fault_clear,
        output fault, strike_count, window_done, enc_delta, hall_delta
    );
endinterface

// File: rtl/bldc_encoder_check_scheduler.sv
// Windowed encoder-versus-hall plausibility monitor for one BLDC channel.
// Latches a fault after FAULT_STRIKES consecutive "hall moved, encoder stalled" windows.
module bldc_encoder_check_scheduler #(
    parameter int unsigned ENCODER_COUNTER_WIDTH = 15,
    parameter int unsigned HALL_COUNTER_WIDTH    = 8,
    parameter int unsigned WINDOW_CYCLES         = 50000,
    parameter int unsigned WINDOW_WIDTH          = 16,
    parameter int unsigned ENC_MIN_DELTA         = 2,
    parameter int unsigned HALL_MIN_DELTA        = 3,
    parameter int unsigned FAULT_STRIKES         = 3,
    parameter int unsigned STRIKE_WIDTH          = 4
) (
    input logic                          clk,
    input logic                          reset,
    bldc_encoder_check_scheduler_if.slave bus
);
    localparam int unsigned EW = ENCODER_COUNTER_WIDTH;
    localparam int unsigned HW = HALL_COUNTER_WIDTH;

    localparam logic [EW-1:0]           EncMin    = EW'(ENC_MIN_DELTA);
    localparam logic [HW-1:0]           HallMin   = HW'(HALL_MIN_DELTA);
    localparam logic [WINDOW_WIDTH-1:0] TimerLoad = WINDOW_WIDTH'(WINDOW_CYCLES - 1);
    localparam logic [STRIKE_WIDTH-1:0] StrikeMax = STRIKE_WIDTH'(FAULT_STRIKES);

    typedef enum logic [2:0] {StIdle, StArm, StWindow, StEval, StFault} state_e;

    state_e                  state_q;
    logic [WINDOW_WIDTH-1:0] timer_q;
    logic [EW-1:0]           enc_base_q, enc_pend_q, enc_delta_q;
    logic [HW-1:0]           hall_base_q, hall_pend_q, hall_delta_q;
    logic [STRIKE_WIDTH-1:0] strike_q;
    logic                    fault_q, window_done_q;

    logic [EW-1:0]           enc_abs;
    logic [HW-1:0]           hall_abs;
    logic [STRIKE_WIDTH-1:0] strike_inc;
    logic                    strike_hit;

    // Magnitude of a two's-complement delta; the most-negative code saturates to max positive.
    function automatic logic [EW-1:0] enc_mag(input logic [EW-1:0] d);
        if (!d[EW-1]) return d;
        if (d == {1'b1, {(EW-1){1'b0}}}) return {1'b0, {(EW-1){1'b1}}};
        return -d;
    endfunction

    function automatic logic [HW-1:0] hall_mag(input logic [HW-1:0] d);
        if (!d[HW-1]) return d;
        if (d == {1'b1, {(HW-1){1'b0}}}) return {1'b0, {(HW-1){1'b1}}};
        return -d;
    endfunction

    always_comb begin
        enc_abs    = enc_mag(enc_pend_q);
        hall_abs   = hall_mag(hall_pend_q);
        strike_hit = (hall_abs >= HallMin) && (enc_abs < EncMin);
        strike_inc = strike_q + STRIKE_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            enc_base_q    <= '0;
            hall_base_q   <= '0;
            enc_pend_q    <= '0;
            hall_pend_q   <= '0;
            enc_delta_q   <= '0;
            hall_delta_q  <= '0;
            strike_q      <= '0;
            fault_q       <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            window_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.enable) state_q <= StArm;
                end
                StArm: begin
                    if (!bus.enable) begin
                        state_q  <= StIdle;
                        strike_q <= '0;
                    end else begin
                        enc_base_q  <= bus.enc_count;
                        hall_base_q <= bus.hall_count;
                        timer_q     <= TimerLoad;
                        state_q     <= StWindow;
                    end
                end
                StWindow: begin
                    if (!bus.enable) begin
                        state_q  <= StIdle;
                        strike_q <= '0;
                    end else if (timer_q == '0) begin
                        // End samples become the next baselines so no motion is lost.
                        enc_pend_q  <= bus.enc_count - enc_base_q;
                        hall_pend_q <= bus.hall_count - hall_base_q;
                        enc_base_q  <= bus.enc_count;
                        hall_base_q <= bus.hall_count;
                        state_q     <= StEval;
                    end else begin
                        timer_q <= timer_q - WINDOW_WIDTH'(1);
                    end
                end
                StEval: begin
                    enc_delta_q   <= enc_pend_q;
                    hall_delta_q  <= hall_pend_q;
                    window_done_q <= 1'b1;
                    if (strike_hit && (strike_inc == StrikeMax)) begin
                        strike_q <= strike_inc;
                        fault_q  <= 1'b1;
                        state_q  <= StFault;
                    end else begin
                        strike_q <= strike_hit ? strike_inc : '0;
                        timer_q  <= TimerLoad;
                        state_q  <= bus.enable ? StWindow : StIdle;
                    end
                end
                StFault: begin
                    if (bus.fault_clear) begin
                        fault_q  <= 1'b0;
                        strike_q <= '0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.fault        = fault_q;
    assign bus.strike_count = strike_q;
    assign bus.window_done  = window_done_q;
    assign bus.enc_delta    = enc_delta_q;
    assign bus.hall_delta   = hall_delta_q;
endmodule

// File: tb/tb_bldc_encoder_check_scheduler.sv
// Scoreboard bench: each stimulated window queues its expected result, a monitor pops on window_done.
module tb_bldc_encoder_check_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    bldc_encoder_check_scheduler_if #(
        .ENCODER_COUNTER_WIDTH(15),
        .HALL_COUNTER_WIDTH   (8),
        .STRIKE_WIDTH         (4)
    ) bus ();

    bldc_encoder_check_scheduler #(
        .ENCODER_COUNTER_WIDTH(15),
        .HALL_COUNTER_WIDTH   (8),
        .WINDOW_CYCLES        (8),
        .WINDOW_WIDTH         (16),
        .ENC_MIN_DELTA        (2),
        .HALL_MIN_DELTA       (3),
        .FAULT_STRIKES        (3),
        .STRIKE_WIDTH         (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [14:0] enc;
        logic [7:0]  hall;
        logic [3:0]  strike;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every window_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.window_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_window_done", 32'(bus.window_done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("enc_delta", 32'(bus.enc_delta), 32'(e.enc));
                check("hall_delta", 32'(bus.hall_delta), 32'(e.hall));
                check("strike_count", 32'(bus.strike_count), 32'(e.strike));
                check("fault", 32'(bus.fault), 32'(e.fault));
            end
        end
    end

    // Called on a negedge inside a window: new counter values land in this window.
    task automatic do_window(input logic [14:0] e_new, input logic [7:0] h_new,
                             input logic [14:0] ede, input logic [7:0] edh,
                             input logic [3:0] es, input logic ef);
        exp_t x;
        int   n;
        n = 0;
        bus.enc_count  = e_new;
        bus.hall_count = h_new;
        x.enc    = ede;
        x.hall   = edh;
        x.strike = es;
        x.fault  = ef;
        exp_q.push_back(x);
        do begin
            @(negedge clk);
            n++;
        end while (bus.window_done !== 1'b1 && n < 20);
        check("window_period", 32'(n), 32'd9);
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fault"}, 32'(bus.fault), 32'd0);
        check({tag, "_strike"}, 32'(bus.strike_count), 32'd0);
        check({tag, "_window_done"}, 32'(bus.window_done), 32'd0);
        check({tag, "_enc_delta"}, 32'(bus.enc_delta), 32'd0);
        check({tag, "_hall_delta"}, 32'(bus.hall_delta), 32'd0);
    endtask

    task automatic clear_fault();
        @(negedge clk);
        bus.fault_clear = 1'b1;
        @(negedge clk);
        bus.fault_clear = 1'b0;
        check("clear_fault", 32'(bus.fault), 32'd0);
        check("clear_strike", 32'(bus.strike_count), 32'd0);
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.enc_count   = '0;
        bus.hall_count  = '0;
        bus.fault_clear = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset");
        wait_neg(2);
        reset = 1'b1;
        wait_neg(2);

        // Healthy motion
        bus.enable = 1'b1;
        wait_neg(2);
        for (int i = 1; i <= 5; i++)
            do_window(15'(10 * i), 8'(4 * i), 15'd10, 8'd4, 4'd0, 1'b0);

        // Threshold boundaries, hall saturation, strike reset, negative motion
        do_window(15'd51, 8'd23, 15'd1, 8'd3, 4'd1, 1'b0);
        do_window(15'd51, 8'd151, 15'd0, 8'h80, 4'd2, 1'b0);
        do_window(15'd53, 8'd154, 15'd2, 8'd3, 4'd0, 1'b0);
        do_window(15'd54, 8'd156, 15'd1, 8'd2, 4'd0, 1'b0);
        do_window(15'd54, 8'd160, 15'd0, 8'd4, 4'd1, 1'b0);
        do_window(15'd44, 8'd156, 15'h7FF6, 8'hFC, 4'd0, 1'b0);

        // Wrap-around
        do_window(15'h7FFE, 8'hFE, 15'h7FD2, 8'h62, 4'd0, 1'b0);
        do_window(15'h0003, 8'h02, 15'd5, 8'd4, 4'd0, 1'b0);

        // Stalled encoder to fault; enable ignored while faulted
        do_window(15'd3, 8'd6, 15'd0, 8'd4, 4'd1, 1'b0);
        do_window(15'd3, 8'd10, 15'd0, 8'd4, 4'd2, 1'b0);
        do_window(15'd3, 8'd14, 15'd0, 8'd4, 4'd3, 1'b1);
        bus.enable = 1'b0;
        wait_neg(20);
        check("fault_held", 32'(bus.fault), 32'd1);
        check("fault_strike_held", 32'(bus.strike_count), 32'd3);
        bus.enable = 1'b1;
        wait_neg(5);

        // Clear and re-arm
        clear_fault();
        wait_neg(2);
        do_window(15'd13, 8'd18, 15'd10, 8'd4, 4'd0, 1'b0);

        // Enable drop after two strikes
        do_window(15'd13, 8'd22, 15'd0, 8'd4, 4'd1, 1'b0);
        do_window(15'd13, 8'd26, 15'd0, 8'd4, 4'd2, 1'b0);
        wait_neg(3);
        bus.enable = 1'b0;
        @(negedge clk);
        check("drop_strike", 32'(bus.strike_count), 32'd0);
        check("drop_enc_delta", 32'(bus.enc_delta), 32'd0);
        check("drop_hall_delta", 32'(bus.hall_delta), 32'd4);
        check("drop_fault", 32'(bus.fault), 32'd0);
        bus.hall_count = 8'd30;
        wait_neg(20);
        bus.enable = 1'b1;
        wait_neg(2);
        do_window(15'd13, 8'd34, 15'd0, 8'd4, 4'd1, 1'b0);
        do_window(15'd13, 8'd38, 15'd0, 8'd4, 4'd2, 1'b0);
        do_window(15'd13, 8'd42, 15'd0, 8'd4, 4'd3, 1'b1);
        clear_fault();
        wait_neg(2);
        do_window(15'd13, 8'd46, 15'd0, 8'd4, 4'd1, 1'b0);

        // Async reset mid-window: window discarded, outputs cleared without a clock edge
        wait_neg(3);
        #2;
        reset      = 1'b0;
        bus.enable = 1'b0;
        #1 check_reset_outputs("rst_window");
        @(negedge clk);
        reset = 1'b1;
        wait_neg(5);

        // Async reset while faulted
        bus.enable = 1'b1;
        wait_neg(2);
        do_window(15'd13, 8'd50, 15'd0, 8'd4, 4'd1, 1'b0);
        do_window(15'd13, 8'd54, 15'd0, 8'd4, 4'd2, 1'b0);
        do_window(15'd13, 8'd58, 15'd0, 8'd4, 4'd3, 1'b1);
        check("pre_reset_fault", 32'(bus.fault), 32'd1);
        #2;
        reset      = 1'b0;
        bus.enable = 1'b0;
        #1 check_reset_outputs("rst_fault");
        @(negedge clk);
        reset = 1'b1;
        wait_neg(20);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bldc_encoder_check_scheduler.md
# bldc_encoder_check_scheduler

Windowed plausibility monitor that schedules encoder-versus-hall consistency checks for one BLDC channel. Captures the free-running encoder and hall counters at fixed window boundaries and computes wrap-aware deltas. Counts consecutive "hall moved, encoder did not" windows and latches a fault after a configurable number of strikes. Sits between the per-motor encoder/hall counters and the motor enable logic. The fault is cleared only by an explicit request.

## Interface
- ENCODER_COUNTER_WIDTH, 15, width of the encoder counter input
- HALL_COUNTER_WIDTH, 8, width of the hall counter input
- WINDOW_CYCLES, 50000, clk cycles per measurement window (>= 2)
- WINDOW_WIDTH, 16, width of the window timer (must hold WINDOW_CYCLES-1)
- ENC_MIN_DELTA, 2, encoder |delta| below this counts as "encoder stalled"
- HALL_MIN_DELTA, 3, hall |delta| at or above this counts as "hall moving"
- FAULT_STRIKES, 3, consecutive strike windows that latch the fault (>= 1)
- STRIKE_WIDTH, 4, width of the strike counter (must hold FAULT_STRIKES)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  monitoring enabled (motor driven)
- enc_count  input  ENCODER_COUNTER_WIDTH  free-running encoder counter, two's-complement, wraps
- hall_count  input  HALL_COUNTER_WIDTH  free-running hall counter, two's-complement, wraps
- fault_clear  input  1  request to clear a latched fault
- fault  output  1  latched consistency fault
- strike_count  output  STRIKE_WIDTH  current consecutive-strike count
- window_done  output  1  one-cycle pulse when a window has been evaluated
- enc_delta  output  ENCODER_COUNTER_WIDTH  signed encoder delta of the last evaluated window
- hall_delta  output  HALL_COUNTER_WIDTH  signed hall delta of the last evaluated window

## Operation
- States: IDLE, ARM, WINDOW, EVAL, FAULT.
- IDLE: if enable, go to ARM. Otherwise remain.
- ARM (1 cycle):
  - Register enc_count and hall_count as the baselines.
  - Load the timer with WINDOW_CYCLES-1.
  - Go to WINDOW.
- WINDOW: decrement the timer each cycle. On the cycle the timer is 0:
  - Register the end samples.
  - Compute deltas as end minus baseline, modulo 2^width, interpreted signed. A wrap such as 0x7FFF to 0x0001 yields +2.
  - Copy the end samples into the baselines so no motion is lost between windows.
  - Go to EVAL.
- EVAL (1 cycle):
  - Update enc_delta and hall_delta and pulse window_done.
  - Strike condition: |hall_delta| >= HALL_MIN_DELTA and |enc_delta| < ENC_MIN_DELTA.
  - On a strike, strike_count increments. On a non-strike, strike_count clears to 0.
  - If the incremented count equals FAULT_STRIKES, set fault and go to FAULT.
  - Otherwise reload the timer with WINDOW_CYCLES-1 and return to WINDOW.
- Magnitudes: the most-negative value saturates to the maximum positive value.
- FAULT: fault held at 1; enable is ignored. When fault_clear is sampled high:
  - Next cycle: fault=0, strike_count=0, state IDLE.
  - fault_clear in any other state is ignored.
- enable low in ARM or WINDOW: next state is IDLE and strike_count clears. Deltas and fault are unchanged.
- enable low during EVAL: EVAL completes normally, including the fault latch. If EVAL does not fault, the next state is IDLE.
- strike_count never exceeds FAULT_STRIKES.

## Timing
- Reset (reset low, asynchronous): state IDLE, fault=0, strike_count=0, window_done=0, enc_delta=0, hall_delta=0, timer=0, baselines=0.
- Reset asserted mid-window discards the window. There is no window_done pulse and no strike update.
- enable rising edge:
  - ARM is entered on the next edge.
  - The first end sample is taken WINDOW_CYCLES cycles after ARM.
  - window_done pulses one cycle later.
- Steady-state window_done period: WINDOW_CYCLES+1 cycles.
- fault rises in the same cycle as the final window_done pulse.
- fault falls one cycle after fault_clear is sampled high.

## Test plan
Parameters for all scenarios: WINDOW_CYCLES=8, FAULT_STRIKES=3.
- **Healthy motion:** enable=1; encoder +10 and hall +4 per window for 5 windows.
  - Required: window_done every 9 cycles; enc_delta=10, hall_delta=4; strike_count=0; fault=0.
- **Stalled encoder:** encoder static, hall +4 per window.
  - Required: strike_count 1, 2, 3.
  - Required: fault=1 coincident with the 3rd window_done.
  - Required: no further window_done pulses while in FAULT.
- **Strike reset:** strike, strike, healthy, strike.
  - Required: strike_count sequence 1, 2, 0, 1; fault stays 0.
- **Wrap:** enc_count steps 0x7FFE to 0x0003 and hall_count steps 0xFE to 0x02 within one window.
  - Required: enc_delta=+5, hall_delta=+4, no strike.
- **Enable drop and clear:**
  - enable=0 mid-window after 2 strikes: strike_count=0, state IDLE, no window_done.
  - Then reach FAULT and pulse fault_clear.
  - Required: fault=0 one cycle later; re-arm occurs if enable=1.
- **Async reset:** assert reset mid-WINDOW and in FAULT.
  - Required: all outputs take their reset values immediately, without waiting for a clk edge.
